// File: rtl/at_cmd_responder.sv
// at_cmd_responder: device side of an AT-command link. Parses received bytes
// into lines and answers each non-empty line with "OK\r\n" (line starts "AT")
// or "ERROR\r\n" on an 8N1 serial transmitter with a one-deep reply slot.
// Optional macro AT_RESP_CNT_EN adds ok_cnt/err_cnt completed-reply counters.
module at_cmd_responder #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int MAX_LEN  = 16
) (
    input  logic       iCLK,
    input  logic       RST_n,
    input  logic [7:0] rxd,
    input  logic       RECEIVE_END,
    output logic       tx,
    output logic       busy,
    output logic       reply_drop
`ifdef AT_RESP_CNT_EN
    ,
    output logic [7:0] ok_cnt,
    output logic [7:0] err_cnt
`endif
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int LEN_W    = $clog2(MAX_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_SAT  = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tx_state_t;

    // Reply text ROM; is_err selects ERROR over OK.
    function automatic logic [7:0] rom_char(input logic is_err, input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h0A;
        if (is_err) begin
            case (idx)
                3'd0:             c = 8'h45;
                3'd1, 3'd2, 3'd4: c = 8'h52;
                3'd3:             c = 8'h4F;
                3'd5:             c = 8'h0D;
                default:          c = 8'h0A;
            endcase
        end else begin
            case (idx)
                3'd0:    c = 8'h4F;
                3'd1:    c = 8'h4B;
                3'd2:    c = 8'h0D;
                default: c = 8'h0A;
            endcase
        end
        return c;
    endfunction

    function automatic logic [2:0] last_idx(input logic is_err);
        return is_err ? 3'd6 : 3'd3;
    endfunction

    tx_state_t        state, state_n;
    logic [LEN_W-1:0] len;
    logic [7:0]       c0, c1;
    logic             dec_vld, dec_err;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n, chr_idx, idx_n;
    logic             kind, kind_n;
    logic [7:0]       chr, chr_n;
    logic             pend_vld, pend_vld_n, pend_err, pend_err_n;
    logic             tx_r, tx_n;
    logic             baud_end, reply_done, take_pend, take_dec, drop;

    assign baud_end   = (cnt == CNT_LAST);
    assign reply_done = (state == STOP) && baud_end && (chr_idx == last_idx(kind));
    assign tx         = tx_r;
    assign busy       = (state != IDLE);
    assign reply_drop = drop;

    // Line parser control: saturating length and a one-cycle decision strobe per terminated line.
    always_ff @(posedge iCLK) begin
        if (!RST_n) begin
            len     <= '0;
            dec_vld <= 1'b0;
        end else begin
            dec_vld <= 1'b0;
            if (RECEIVE_END) begin
                if (rxd == 8'h0A) begin
                    len     <= '0;
                    dec_vld <= (len != '0);
                end else if (rxd != 8'h0D) begin
                    if (len != LEN_SAT) len <= len + 1'b1;
                end
            end
        end
    end

    // First two characters and reply kind; only meaningful alongside len/dec_vld, so unreset.
    always_ff @(posedge iCLK) begin
        if (RECEIVE_END && rxd != 8'h0A && rxd != 8'h0D) begin
            if (len == LEN_W'(0)) c0 <= rxd;
            if (len == LEN_W'(1)) c1 <= rxd;
        end
        dec_err <= !(len >= LEN_W'(2) && len <= LEN_MAX && c0 == 8'h41 && c1 == 8'h54);
    end

    // Transmitter and pending-slot registers; only control state is reset.
    always_ff @(posedge iCLK) begin
        cnt      <= cnt_n;
        bit_idx  <= bit_n;
        chr_idx  <= idx_n;
        kind     <= kind_n;
        chr      <= chr_n;
        pend_err <= pend_err_n;
        if (!RST_n) begin
            state    <= IDLE;
            pend_vld <= 1'b0;
            tx_r     <= 1'b1;
        end else begin
            state    <= state_n;
            pend_vld <= pend_vld_n;
            tx_r     <= tx_n;
        end
    end

    // Transmitter next state, reply queueing and registered serial bit.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_n      = bit_idx;
        idx_n      = chr_idx;
        kind_n     = kind;
        chr_n      = chr;
        pend_vld_n = pend_vld;
        pend_err_n = pend_err;
        take_pend  = 1'b0;
        take_dec   = 1'b0;
        drop       = 1'b0;
        tx_n       = 1'b1;

        case (state)
            IDLE: begin
                if (pend_vld)     take_pend = 1'b1;
                else if (dec_vld) take_dec  = 1'b1;
            end
            LOAD: begin
                chr_n   = rom_char(kind, chr_idx);
                cnt_n   = '0;
                state_n = START;
            end
            START: begin
                if (baud_end) begin
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    cnt_n = '0;
                    if (reply_done) begin
                        // A waiting reply follows immediately so busy never dips.
                        if (pend_vld) take_pend = 1'b1;
                        else          state_n   = IDLE;
                    end else begin
                        idx_n   = chr_idx + 3'd1;
                        state_n = LOAD;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (take_pend || take_dec) begin
            state_n = LOAD;
            idx_n   = 3'd0;
            kind_n  = take_pend ? pend_err : dec_err;
        end
        if (take_pend) pend_vld_n = 1'b0;

        // A decision not sent directly fills the slot, which may be freeing this cycle.
        if (dec_vld && !take_dec) begin
            if (!pend_vld || take_pend) begin
                pend_vld_n = 1'b1;
                pend_err_n = dec_err;
            end else begin
                drop = 1'b1;
            end
        end

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = chr_n[bit_n];
            default: tx_n = 1'b1;
        endcase
    end

`ifdef AT_RESP_CNT_EN
    // Completed-reply counters, wrapping 255 -> 0.
    always_ff @(posedge iCLK) begin
        if (!RST_n) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else if (reply_done) begin
            if (kind) err_cnt <= err_cnt + 8'd1;
            else      ok_cnt  <= ok_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_at_cmd_responder.sv
// Bench for at_cmd_responder: transaction-level reference model checked every
// cycle, a serial decoder for the reply bytes, directed and random lines.
module tb_at_cmd_responder;

    localparam int CLK_FREQ = 500;
    localparam int BAUD     = 100;
    localparam int MAX_LEN  = 16;
    localparam int D        = CLK_FREQ / BAUD;
    localparam int F        = 1 + 10 * D;

    logic       iCLK = 1'b0;
    logic       RST_n = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic       RECEIVE_END = 1'b0;
    logic       tx, busy, reply_drop;
`ifdef AT_RESP_CNT_EN
    logic [7:0] ok_cnt, err_cnt;
`endif

    at_cmd_responder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_LEN(MAX_LEN)) dut (
        .iCLK(iCLK), .RST_n(RST_n), .rxd(rxd), .RECEIVE_END(RECEIVE_END),
        .tx(tx), .busy(busy), .reply_drop(reply_drop)
`ifdef AT_RESP_CNT_EN
        , .ok_cnt(ok_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    byte unsigned ok_str [4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    byte unsigned err_str[7] = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0D, 8'h0A};
    int         m_cyc = 0;
    bit         m_started = 0;
    int         m_len = 0;
    logic [7:0] m_c0 = 0, m_c1 = 0;
    bit         m_dec_v = 0, m_dec_k = 0;
    bit         m_act = 0, m_kind = 0;
    int         m_s = 0;
    bit         m_pend_v = 0, m_pend_k = 0;
    int         m_ok = 0, m_err = 0;

    byte unsigned rx_q[$];
    int drop_seen = 0;
    int busy_rises = 0;

    function automatic int n_chars(input bit is_err);
        return is_err ? 7 : 4;
    endfunction

    function automatic byte unsigned reply_char(input bit is_err, input int j);
        return is_err ? err_str[j] : ok_str[j];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, m_cyc);
        end
    endtask

    // Model: advances one clock edge using the inputs sampled at that edge.
    initial begin : model
        bit dv, dk, used, fin;
        forever begin
            @(posedge iCLK);
            m_cyc++;
            if (!RST_n) begin
                m_started = 1;
                m_len = 0; m_dec_v = 0; m_act = 0; m_pend_v = 0; m_ok = 0; m_err = 0;
            end else begin
                dv = m_dec_v;
                dk = m_dec_k;
                m_dec_v = 0;
                if (RECEIVE_END) begin
                    if (rxd == 8'h0A) begin
                        if (m_len > 0) begin
                            m_dec_v = 1;
                            m_dec_k = !(m_len >= 2 && m_len <= MAX_LEN && m_c0 == 8'h41 && m_c1 == 8'h54);
                        end
                        m_len = 0;
                    end else if (rxd != 8'h0D) begin
                        if (m_len == 0) m_c0 = rxd;
                        if (m_len == 1) m_c1 = rxd;
                        if (m_len < MAX_LEN + 1) m_len++;
                    end
                end
                fin = m_act && (m_cyc - m_s == n_chars(m_kind) * F);
                if (fin) begin
                    m_act = 0;
                    if (m_kind) m_err = (m_err + 1) % 256;
                    else        m_ok  = (m_ok + 1) % 256;
                end
                used = 0;
                if (!m_act) begin
                    if (m_pend_v) begin
                        m_act = 1; m_s = m_cyc; m_kind = m_pend_k; m_pend_v = 0;
                    end else if (dv && !fin) begin
                        m_act = 1; m_s = m_cyc; m_kind = dk; used = 1;
                    end
                end
                if (dv && !used && !m_pend_v) begin
                    m_pend_v = 1;
                    m_pend_k = dk;
                end
            end
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    initial begin : compare
        bit exp_tx, exp_busy, exp_drop, next_fin;
        int t, w, b;
        byte unsigned c;
        forever begin
            @(negedge iCLK);
            if (m_started) begin
                exp_busy = m_act;
                exp_tx   = 1'b1;
                if (m_act) begin
                    t = m_cyc - m_s;
                    w = t % F;
                    if (w != 0) begin
                        b = (w - 1) / D;
                        c = reply_char(m_kind, t / F);
                        if (b == 0)      exp_tx = 1'b0;
                        else if (b <= 8) exp_tx = c[b-1];
                    end
                end
                next_fin = m_act && (m_cyc + 1 - m_s == n_chars(m_kind) * F);
                exp_drop = m_dec_v && m_pend_v && m_act && !next_fin;
                chk("tx", tx, exp_tx);
                chk("busy", busy, exp_busy);
                chk("reply_drop", reply_drop, exp_drop);
`ifdef AT_RESP_CNT_EN
                chk("ok_cnt", ok_cnt, m_ok);
                chk("err_cnt", err_cnt, m_err);
`endif
            end
        end
    end

    // Serial decoder: samples each bit in its middle and queues received bytes.
    initial begin : decoder
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge iCLK);
            if (prev === 1'b1 && tx === 1'b0) begin
                repeat (D / 2) @(negedge iCLK);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (D) @(negedge iCLK);
                        b[i] = tx;
                    end
                    repeat (D) @(negedge iCLK);
                    rx_q.push_back(b);
                end
            end
            prev = tx;
        end
    end

    initial begin : monitor
        logic pb;
        pb = 1'b0;
        forever begin
            @(negedge iCLK);
            if (reply_drop === 1'b1) drop_seen++;
            if (busy === 1'b1 && pb !== 1'b1) busy_rises++;
            pb = busy;
        end
    end

    initial begin : watchdog
        #(10 * 99000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rxd = b;
        RECEIVE_END = 1'b1;
        @(negedge iCLK);
        RECEIVE_END = 1'b0;
        repeat (gap) @(negedge iCLK);
    endtask

    task automatic send_at(input int gap);
        send_byte(8'h41, gap);
        send_byte(8'h54, gap);
        send_byte(8'h0A, gap);
    endtask

    task automatic wait_idle();
        int quiet, n;
        quiet = 0;
        n = 0;
        while (quiet < D + 3 && n < 20000) begin
            @(negedge iCLK);
            n++;
            if (busy === 1'b0) quiet++;
            else               quiet = 0;
        end
        chk("idle_timeout", (n >= 20000), 0);
    endtask

    // Compare decoded bytes against literal reply text (kind: 0 OK, 1 ERROR, -1 none).
    task automatic check_rx(input string name, input int k0, input int k1);
        byte unsigned exp[$];
        int ks[2];
        ks[0] = k0;
        ks[1] = k1;
        for (int r = 0; r < 2; r++) begin
            if (ks[r] == 0) begin
                exp.push_back(8'h4F); exp.push_back(8'h4B); exp.push_back(8'h0D); exp.push_back(8'h0A);
            end else if (ks[r] == 1) begin
                exp.push_back(8'h45); exp.push_back(8'h52); exp.push_back(8'h52); exp.push_back(8'h4F);
                exp.push_back(8'h52); exp.push_back(8'h0D); exp.push_back(8'h0A);
            end
        end
        chk({name, "_count"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) chk(name, rx_q[i], exp[i]);
        rx_q.delete();
    endtask

    initial begin : stimulus
        int k, n, d0, r0;
        repeat (3) @(negedge iCLK);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_drop", reply_drop, 0);
        RST_n = 1'b1;
        repeat (2) @(negedge iCLK);

        // "AT\r\n" with latency and reply length pinned
        send_byte(8'h41, 1);
        send_byte(8'h54, 1);
        send_byte(8'h0D, 1);
        k = m_cyc + 1;
        send_byte(8'h0A, 0);
        chk("busy_after_k", busy, 0);
        @(negedge iCLK);
        chk("busy_after_k1", busy, 1);
        chk("tx_after_k1", tx, 1);
        @(negedge iCLK);
        chk("tx_start_after_k2", tx, 0);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge iCLK);
            n++;
        end
        chk("busy_fall_edge", m_cyc, k + 1 + 4 * F);
        wait_idle();
        check_rx("ok_reply", 0, -1);

        // "XY\n" -> ERROR
        send_byte(8'h58, 0);
        send_byte(8'h59, 0);
        send_byte(8'h0A, 0);
        wait_idle();
        check_rx("xy_reply", 1, -1);

        // "\r\n" -> nothing
        r0 = busy_rises;
        send_byte(8'h0D, 0);
        send_byte(8'h0A, 0);
        repeat (3 * D) @(negedge iCLK);
        wait_idle();
        chk("empty_line_busy_rises", busy_rises - r0, 0);
        check_rx("empty_line", -1, -1);

        // 16 characters still accepted, 17 overflow
        send_byte(8'h41, 0);
        send_byte(8'h54, 0);
        for (int i = 0; i < 14; i++) send_byte(8'h31, 0);
        send_byte(8'h0A, 0);
        wait_idle();
        check_rx("len16_reply", 0, -1);
        send_byte(8'h41, 0);
        send_byte(8'h54, 0);
        for (int i = 0; i < 15; i++) send_byte(8'h31, 0);
        send_byte(8'h0A, 0);
        wait_idle();
        check_rx("len17_reply", 1, -1);

        // lower-case "at" -> ERROR
        send_byte(8'h61, 0);
        send_byte(8'h74, 0);
        send_byte(8'h0A, 0);
        wait_idle();
        check_rx("lower_at_reply", 1, -1);

        // back-to-back replies with one dropped decision
        d0 = drop_seen;
        r0 = busy_rises;
        send_at(0);
        send_byte(8'h42, 0);
        send_byte(8'h0A, 0);
        send_at(0);
        wait_idle();
        chk("b2b_drops", drop_seen - d0, 1);
        chk("b2b_busy_rises", busy_rises - r0, 1);
        check_rx("b2b_reply", 0, 1);

        // reset during DATA of the second reply character
        send_at(0);
        repeat (1 + F + 3 * D) @(negedge iCLK);
        chk("pre_reset_busy", busy, 1);
        RST_n = 1'b0;
        @(negedge iCLK);
        chk("mid_reset_tx", tx, 1);
        chk("mid_reset_busy", busy, 0);
        RST_n = 1'b1;
        repeat (20 * D) @(negedge iCLK);
        rx_q.delete();
        send_at(0);
        wait_idle();
        check_rx("after_reset_reply", 0, -1);

        // random lines, including lines sent while replies are in flight
        for (int l = 0; l < 30; l++) begin
            int len;
            bit at;
            logic [7:0] c;
            len = $urandom_range(0, 18);
            at  = $urandom_range(0, 1);
            for (int i = 0; i < len; i++) begin
                if (at && i == 0)      c = 8'h41;
                else if (at && i == 1) c = 8'h54;
                else begin
                    case ($urandom_range(0, 4))
                        0:       c = 8'h41;
                        1:       c = 8'h54;
                        2:       c = 8'h61;
                        3:       c = 8'h31;
                        default: c = 8'h0D;
                    endcase
                end
                send_byte(c, $urandom_range(0, 2));
            end
            send_byte(8'h0A, 0);
            repeat ($urandom_range(0, 400)) @(negedge iCLK);
        end
        wait_idle();
        rx_q.delete();

`ifdef AT_RESP_CNT_EN
        // counters: 3 OK + 1 ERROR, then 256 OK wraps back to 0
        RST_n = 1'b0;
        @(negedge iCLK);
        RST_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_at(0);
            wait_idle();
        end
        send_byte(8'h42, 0);
        send_byte(8'h0A, 0);
        wait_idle();
        chk("ok_cnt_3", ok_cnt, 3);
        chk("err_cnt_1", err_cnt, 1);
        RST_n = 1'b0;
        @(negedge iCLK);
        RST_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_at(0);
            wait_idle();
        end
        chk("ok_cnt_wrap", ok_cnt, 0);
        chk("err_cnt_zero", err_cnt, 0);
        rx_q.delete();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
